// File: rtl/regfile_pkg.sv
// Shared types and helpers for the multi-port register file.
// Optional feature macro used by regfile_mp: REGFILE_BYPASS_EN.
package regfile_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } clr_state_e;

    localparam int XLEN_D  = 32;
    localparam int NREGS_D = 32;

    function automatic int addr_w(input int n);
        return $clog2(n);
    endfunction

endpackage

// File: rtl/regfile_if.sv
// Bus bundle between decode/writeback and the register file.
// master drives requests; slave (the register file) returns data and status.
interface regfile_if
    import regfile_pkg::*;
#(
    parameter int XLEN  = XLEN_D,
    parameter int NREGS = NREGS_D,
    parameter int NRD   = 2
);
    localparam int AW = addr_w(NREGS);

    logic [NRD-1:0]           rd_en;
    logic [NRD-1:0][AW-1:0]   rd_addr;
    logic [NRD-1:0][XLEN-1:0] rd_data;
    logic [NRD-1:0]           rd_busy;
    logic [NRD-1:0]           rd_valid;

    logic                     wr_valid;
    logic                     wr_ready;
    logic [AW-1:0]            wr_addr;
    logic [XLEN-1:0]          wr_data;

    logic                     sb_set;
    logic [AW-1:0]            sb_addr;
    logic [NREGS-1:0]         busy;

    logic                     clr_req;
    logic                     clr_busy;
    logic                     clr_done;

    modport master (
        output rd_en, rd_addr, wr_valid, wr_addr, wr_data, sb_set, sb_addr, clr_req,
        input  rd_data, rd_busy, rd_valid, wr_ready, busy, clr_busy, clr_done
    );

    modport slave (
        input  rd_en, rd_addr, wr_valid, wr_addr, wr_data, sb_set, sb_addr, clr_req,
        output rd_data, rd_busy, rd_valid, wr_ready, busy, clr_busy, clr_done
    );

endinterface

// File: rtl/regfile_clear_fsm.sv
// Clear sequencer: sweeps every register index once, one per cycle, and
// blocks the write port while the sweep runs.
module regfile_clear_fsm
    import regfile_pkg::*;
#(
    parameter int NREGS = NREGS_D,
    parameter int AW    = addr_w(NREGS)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr_req,
    output logic          clr_busy,
    output logic          clr_done,
    output logic          wr_ready,
    output logic          clr_we,
    output logic [AW-1:0] clr_idx
);

    localparam logic [AW-1:0] LAST_IDX = AW'(NREGS - 1);

    clr_state_e    state_q, state_d;
    logic [AW-1:0] idx_q, idx_d;

    // State and sweep index; reset abandons a sweep without signalling completion.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    // Next state and outputs: IDLE waits for clr_req, CLEAR walks idx to the last register.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        clr_busy = 1'b0;
        clr_done = 1'b0;
        wr_ready = 1'b1;
        clr_we   = 1'b0;
        clr_idx  = idx_q;
        case (state_q)
            IDLE: begin
                if (clr_req) begin
                    state_d = CLEAR;
                    idx_d   = '0;
                end
            end
            CLEAR: begin
                clr_busy = 1'b1;
                wr_ready = 1'b0;
                clr_we   = 1'b1;
                idx_d    = idx_q + AW'(1);
                if (idx_q == LAST_IDX) begin
                    clr_done = 1'b1;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file with registered reads, one handshaked write port,
// per-register busy scoreboard and a hardware clear sweep.
// REGFILE_BYPASS_EN: when defined, a read of the register being written in the
// same cycle returns the new data with busy=0; otherwise it returns the old contents.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int XLEN     = XLEN_D,
    parameter int NREGS    = NREGS_D,
    parameter int NRD      = 2,
    parameter int ZERO_REG = 1
) (
    input logic      clk,
    input logic      rst,
    regfile_if.slave bus
);

    localparam int AW = addr_w(NREGS);
    localparam bit ZR = (ZERO_REG != 0);

    logic [XLEN-1:0]          regs_q [NREGS];
    logic [XLEN-1:0]          regs_d [NREGS];
    logic [NREGS-1:0]         busy_q, busy_d;
    logic [NRD-1:0][XLEN-1:0] rd_data_q, rd_data_d;
    logic [NRD-1:0]           rd_busy_q, rd_busy_d;
    logic [NRD-1:0]           rd_valid_q, rd_valid_d;

    logic          clr_busy, clr_done, wr_ready, clr_we;
    logic [AW-1:0] clr_idx;
    logic          wr_fire, wr_ok, sb_ok;

    regfile_clear_fsm #(
        .NREGS (NREGS),
        .AW    (AW)
    ) u_clear_fsm (
        .clk      (clk),
        .rst      (rst),
        .clr_req  (bus.clr_req),
        .clr_busy (clr_busy),
        .clr_done (clr_done),
        .wr_ready (wr_ready),
        .clr_we   (clr_we),
        .clr_idx  (clr_idx)
    );

    // Register 0 is excluded from writes and busy marking when hardwired to zero.
    assign wr_fire = bus.wr_valid && wr_ready;
    assign wr_ok   = wr_fire && !(ZR && (bus.wr_addr == '0));
    assign sb_ok   = bus.sb_set && !clr_busy && !(ZR && (bus.sb_addr == '0));

    // Array and scoreboard update: write clears busy, a same-edge set overrides it.
    always_comb begin
        regs_d = regs_q;
        busy_d = busy_q;
        if (wr_ok) begin
            regs_d[bus.wr_addr] = bus.wr_data;
            busy_d[bus.wr_addr] = 1'b0;
        end
        if (sb_ok) begin
            busy_d[bus.sb_addr] = 1'b1;
        end
        if (clr_we) begin
            regs_d[clr_idx] = '0;
            busy_d[clr_idx] = 1'b0;
        end
        if (ZR) begin
            regs_d[0] = '0;
            busy_d[0] = 1'b0;
        end
    end

    // Read ports: capture addressed data/busy on rd_en, otherwise hold the last result.
    always_comb begin
        rd_data_d  = rd_data_q;
        rd_busy_d  = rd_busy_q;
        rd_valid_d = bus.rd_en;
        for (int i = 0; i < NRD; i++) begin
            if (bus.rd_en[i]) begin
                rd_data_d[i] = regs_q[bus.rd_addr[i]];
                rd_busy_d[i] = busy_q[bus.rd_addr[i]];
`ifdef REGFILE_BYPASS_EN
                if (wr_ok && (bus.wr_addr == bus.rd_addr[i])) begin
                    rd_data_d[i] = bus.wr_data;
                    rd_busy_d[i] = 1'b0;
                end
`endif
            end
        end
    end

    // State registers for array, scoreboard and read ports.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int r = 0; r < NREGS; r++) begin
                regs_q[r] <= '0;
            end
            busy_q     <= '0;
            rd_data_q  <= '0;
            rd_busy_q  <= '0;
            rd_valid_q <= '0;
        end else begin
            regs_q     <= regs_d;
            busy_q     <= busy_d;
            rd_data_q  <= rd_data_d;
            rd_busy_q  <= rd_busy_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    assign bus.rd_data  = rd_data_q;
    assign bus.rd_busy  = rd_busy_q;
    assign bus.rd_valid = rd_valid_q;
    assign bus.wr_ready = wr_ready;
    assign bus.busy     = busy_q;
    assign bus.clr_busy = clr_busy;
    assign bus.clr_done = clr_done;

endmodule

// File: tb/tb_regfile_mp.sv
// Testbench for regfile_mp: reference model plus a queue of expected read results.
`timescale 1ns/1ps
module tb_regfile_mp;
    import regfile_pkg::*;

    localparam int XLEN  = 32;
    localparam int NREGS = 32;
    localparam int NRD   = 2;
    localparam int AW    = 5;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    regfile_if #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD)) bus ();

    regfile_mp #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .ZERO_REG(1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        int              port;
        logic [XLEN-1:0] data;
        logic            busy;
    } rd_exp_t;

    rd_exp_t          sb_q[$];
    int               errors = 0;
    int               checks = 0;
    logic [XLEN-1:0]  m_regs [NREGS];
    logic [NREGS-1:0] m_busy;
    bit               m_clear;
    int               m_idx;

    task automatic model_reset();
        for (int r = 0; r < NREGS; r++) m_regs[r] = '0;
        m_busy  = '0;
        m_clear = 1'b0;
        m_idx   = 0;
        sb_q.delete();
    endtask

    task automatic drive_idle();
        bus.rd_en    = '0;
        bus.rd_addr  = '0;
        bus.wr_valid = 1'b0;
        bus.wr_addr  = '0;
        bus.wr_data  = '0;
        bus.sb_set   = 1'b0;
        bus.sb_addr  = '0;
        bus.clr_req  = 1'b0;
    endtask

    // Push expectations for the reads issued this cycle, advance the model, clock once.
    task automatic step();
        int a;
        for (int i = 0; i < NRD; i++) begin
            if (bus.rd_en[i]) begin
                rd_exp_t e;
                a = int'(bus.rd_addr[i]);
                e.port = i;
                e.data = m_regs[a];
                e.busy = m_busy[a];
`ifdef REGFILE_BYPASS_EN
                if (bus.wr_valid && !m_clear && (bus.wr_addr == bus.rd_addr[i]) && a != 0) begin
                    e.data = bus.wr_data;
                    e.busy = 1'b0;
                end
`endif
                sb_q.push_back(e);
            end
        end
        if (m_clear) begin
            m_regs[m_idx] = '0;
            m_busy[m_idx] = 1'b0;
            if (m_idx == NREGS - 1) m_clear = 1'b0;
            m_idx = (m_idx + 1) % NREGS;
        end else begin
            if (bus.wr_valid && bus.wr_addr != '0) begin
                m_regs[bus.wr_addr] = bus.wr_data;
                m_busy[bus.wr_addr] = 1'b0;
            end
            if (bus.sb_set && bus.sb_addr != '0) m_busy[bus.sb_addr] = 1'b1;
            if (bus.clr_req) begin
                m_clear = 1'b1;
                m_idx   = 0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rd_exp_t e;
        drive_idle();
        model_reset();
        rst = 1'b0;
        #2;
        checks++;
        if (bus.rd_data !== '0 || bus.rd_busy !== '0 || bus.rd_valid !== '0 || bus.busy !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got rd_data=%h rd_busy=%b rd_valid=%b busy=%h, want all zero",
                     bus.rd_data, bus.rd_busy, bus.rd_valid, bus.busy);
        end
        checks++;
        if (bus.wr_ready !== 1'b1 || bus.clr_busy !== 1'b0 || bus.clr_done !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got wr_ready=%b clr_busy=%b clr_done=%b, want 1 0 0",
                     bus.wr_ready, bus.clr_busy, bus.clr_done);
        end
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        bus.rd_en      = '1;
        bus.rd_addr[0] = AW'(0);
        bus.rd_addr[1] = AW'(1);
        step();
        drive_idle();
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            checks++;
            if (bus.rd_data[e.port] !== 32'h0 || bus.rd_busy[e.port] !== 1'b0 || bus.rd_valid[e.port] !== 1'b1) begin
                errors++;
                $display("FAIL reset_read p%0d: got data=%h busy=%b valid=%b, want data=0 busy=0 valid=1",
                         e.port, bus.rd_data[e.port], bus.rd_busy[e.port], bus.rd_valid[e.port]);
            end
        end
    endtask

    task automatic test_write_read();
        rd_exp_t e;
        // Write r5 with a same-cycle read of r5 on port 0.
        bus.wr_valid   = 1'b1;
        bus.wr_addr    = AW'(5);
        bus.wr_data    = 32'hDEADBEEF;
        bus.rd_en      = 2'b01;
        bus.rd_addr[0] = AW'(5);
        step();
        drive_idle();
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            checks++;
            if (bus.rd_data[e.port] !== e.data || bus.rd_busy[e.port] !== e.busy || bus.rd_valid[e.port] !== 1'b1) begin
                errors++;
                $display("FAIL same_cycle_read p%0d: got data=%h busy=%b valid=%b, want data=%h busy=%b valid=1",
                         e.port, bus.rd_data[e.port], bus.rd_busy[e.port], bus.rd_valid[e.port], e.data, e.busy);
            end
        end
        // Read r5 on the following cycle.
        bus.rd_en      = 2'b10;
        bus.rd_addr[1] = AW'(5);
        step();
        drive_idle();
        checks++;
        if (bus.rd_data[1] !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL read_after_write: got %h, want deadbeef", bus.rd_data[1]);
        end
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            checks++;
            if (bus.rd_data[e.port] !== e.data || bus.rd_busy[e.port] !== e.busy || bus.rd_valid[e.port] !== 1'b1) begin
                errors++;
                $display("FAIL next_cycle_read p%0d: got data=%h busy=%b, want data=%h busy=%b",
                         e.port, bus.rd_data[e.port], bus.rd_busy[e.port], e.data, e.busy);
            end
        end
        // No read request: data held, valid low.
        bus.rd_addr[1] = AW'(0);
        step();
        checks++;
        if (bus.rd_valid !== 2'b00 || bus.rd_data[1] !== 32'hDEADBEEF || bus.rd_busy[1] !== 1'b0) begin
            errors++;
            $display("FAIL read_hold: got valid=%b data=%h busy=%b, want valid=00 data=deadbeef busy=0",
                     bus.rd_valid, bus.rd_data[1], bus.rd_busy[1]);
        end
    endtask

    task automatic test_zero_reg();
        rd_exp_t e;
        bus.wr_valid = 1'b1;
        bus.wr_addr  = AW'(0);
        bus.wr_data  = 32'h1234;
        step();
        drive_idle();
        bus.rd_en      = 2'b01;
        bus.rd_addr[0] = AW'(0);
        step();
        drive_idle();
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            checks++;
            if (bus.rd_data[e.port] !== 32'h0 || bus.rd_data[e.port] !== e.data || bus.rd_valid[e.port] !== 1'b1) begin
                errors++;
                $display("FAIL zero_reg_read p%0d: got data=%h valid=%b, want data=0 valid=1",
                         e.port, bus.rd_data[e.port], bus.rd_valid[e.port]);
            end
        end
        bus.sb_set  = 1'b1;
        bus.sb_addr = AW'(0);
        step();
        drive_idle();
        checks++;
        if (bus.busy[0] !== 1'b0) begin
            errors++;
            $display("FAIL zero_reg_busy: got busy[0]=%b, want 0", bus.busy[0]);
        end
    endtask

    task automatic test_scoreboard();
        rd_exp_t e;
        bus.sb_set  = 1'b1;
        bus.sb_addr = AW'(7);
        step();
        drive_idle();
        checks++;
        if (bus.busy[7] !== 1'b1) begin
            errors++;
            $display("FAIL sb_set_r7: got busy[7]=%b, want 1", bus.busy[7]);
        end
        bus.rd_en      = 2'b10;
        bus.rd_addr[1] = AW'(7);
        step();
        drive_idle();
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            checks++;
            if (bus.rd_busy[e.port] !== 1'b1 || bus.rd_busy[e.port] !== e.busy || bus.rd_data[e.port] !== e.data) begin
                errors++;
                $display("FAIL rd_busy_r7 p%0d: got busy=%b data=%h, want busy=1 data=%h",
                         e.port, bus.rd_busy[e.port], bus.rd_data[e.port], e.data);
            end
        end
        bus.wr_valid = 1'b1;
        bus.wr_addr  = AW'(7);
        bus.wr_data  = 32'h55;
        step();
        drive_idle();
        checks++;
        if (bus.busy[7] !== 1'b0) begin
            errors++;
            $display("FAIL write_clears_busy: got busy[7]=%b, want 0", bus.busy[7]);
        end
        bus.wr_valid = 1'b1;
        bus.wr_addr  = AW'(7);
        bus.wr_data  = 32'h66;
        bus.sb_set   = 1'b1;
        bus.sb_addr  = AW'(7);
        step();
        drive_idle();
        checks++;
        if (bus.busy[7] !== 1'b1 || bus.busy !== m_busy) begin
            errors++;
            $display("FAIL set_wins: got busy=%h, want %h with bit 7 set", bus.busy, m_busy);
        end
    endtask

    task automatic test_clear();
        rd_exp_t e;
        int done_cnt;
        int done_at;
        bit busy_bad;
        for (int r = 1; r < NREGS; r++) begin
            bus.wr_valid = 1'b1;
            bus.wr_addr  = AW'(r);
            bus.wr_data  = 32'hA000_0000 + 32'(r * 17 + 1);
            step();
        end
        drive_idle();
        bus.sb_set  = 1'b1;
        bus.sb_addr = AW'(9);
        step();
        drive_idle();
        bus.clr_req = 1'b1;
        step();
        drive_idle();
        done_cnt = 0;
        done_at  = -1;
        busy_bad = 1'b0;
        for (int c = 0; c < NREGS; c++) begin
            if (bus.clr_busy !== 1'b1 || bus.wr_ready !== 1'b0) busy_bad = 1'b1;
            if (bus.clr_done === 1'b1) begin
                done_cnt++;
                done_at = c;
            end
            bus.wr_valid   = 1'b1;
            bus.wr_addr    = AW'(3);
            bus.wr_data    = 32'hBAD0_0BAD;
            bus.sb_set     = (c == 20);
            bus.sb_addr    = AW'(2);
            bus.clr_req    = (c == 5);
            bus.rd_en      = 2'b11;
            bus.rd_addr[0] = AW'(c);
            bus.rd_addr[1] = AW'((c + NREGS - 1) % NREGS);
            step();
            drive_idle();
            while (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                checks++;
                if (bus.rd_data[e.port] !== e.data || bus.rd_busy[e.port] !== e.busy) begin
                    errors++;
                    $display("FAIL sweep_read c%0d p%0d: got data=%h busy=%b, want data=%h busy=%b",
                             c, e.port, bus.rd_data[e.port], bus.rd_busy[e.port], e.data, e.busy);
                end
            end
        end
        checks++;
        if (busy_bad) begin
            errors++;
            $display("FAIL sweep_ctrl: clr_busy/wr_ready not 1/0 on every sweep cycle");
        end
        checks++;
        if (done_cnt != 1 || done_at != NREGS - 1) begin
            errors++;
            $display("FAIL clr_done_pulse: got count=%0d last_at=%0d, want count=1 at=%0d",
                     done_cnt, done_at, NREGS - 1);
        end
        checks++;
        if (bus.clr_busy !== 1'b0 || bus.wr_ready !== 1'b1 || bus.busy !== '0) begin
            errors++;
            $display("FAIL after_sweep: got clr_busy=%b wr_ready=%b busy=%h, want 0 1 0",
                     bus.clr_busy, bus.wr_ready, bus.busy);
        end
        for (int r = 0; r < NREGS; r += 2) begin
            bus.rd_en      = 2'b11;
            bus.rd_addr[0] = AW'(r);
            bus.rd_addr[1] = AW'(r + 1);
            step();
            drive_idle();
            while (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                checks++;
                if (bus.rd_data[e.port] !== 32'h0 || bus.rd_data[e.port] !== e.data) begin
                    errors++;
                    $display("FAIL cleared_read r%0d: got %h, want 0", r + e.port, bus.rd_data[e.port]);
                end
            end
        end
    endtask

    task automatic test_reset_mid_sweep();
        rd_exp_t e;
        bit done_seen;
        bus.wr_valid = 1'b1;
        bus.wr_addr  = AW'(4);
        bus.wr_data  = 32'hA5A5_A5A5;
        bus.sb_set   = 1'b1;
        bus.sb_addr  = AW'(30);
        step();
        drive_idle();
        bus.rd_en      = 2'b11;
        bus.rd_addr[0] = AW'(4);
        bus.rd_addr[1] = AW'(30);
        step();
        drive_idle();
        sb_q.delete();
        bus.clr_req = 1'b1;
        step();
        drive_idle();
        done_seen = 1'b0;
        for (int c = 0; c < 10; c++) begin
            bus.rd_en      = 2'b01;
            bus.rd_addr[0] = AW'(4);
            step();
            drive_idle();
            if (bus.clr_done === 1'b1) done_seen = 1'b1;
        end
        sb_q.delete();
        #1;
        rst = 1'b0;
        #1;
        checks++;
        if (bus.rd_data !== '0 || bus.rd_busy !== '0 || bus.rd_valid !== '0 || bus.busy !== '0) begin
            errors++;
            $display("FAIL midsweep_reset_data: got rd_data=%h rd_busy=%b rd_valid=%b busy=%h, want all zero",
                     bus.rd_data, bus.rd_busy, bus.rd_valid, bus.busy);
        end
        checks++;
        if (bus.clr_busy !== 1'b0 || bus.clr_done !== 1'b0 || bus.wr_ready !== 1'b1 || done_seen) begin
            errors++;
            $display("FAIL midsweep_reset_ctrl: got clr_busy=%b clr_done=%b wr_ready=%b early_done=%b, want 0 0 1 0",
                     bus.clr_busy, bus.clr_done, bus.wr_ready, done_seen);
        end
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        for (int c = 0; c < NREGS + 2; c++) begin
            step();
            if (bus.clr_done === 1'b1 || bus.clr_busy === 1'b1) done_seen = 1'b1;
        end
        checks++;
        if (done_seen) begin
            errors++;
            $display("FAIL abandoned_sweep: clr_done or clr_busy rose after reset, want both 0");
        end
        bus.rd_en      = 2'b01;
        bus.rd_addr[0] = AW'(4);
        step();
        drive_idle();
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            checks++;
            if (bus.rd_data[e.port] !== 32'h0 || bus.rd_data[e.port] !== e.data) begin
                errors++;
                $display("FAIL reset_cleared_r4: got %h, want 0", bus.rd_data[e.port]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_zero_reg();
        test_scoreboard();
        test_clear();
        test_reset_mid_sweep();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached before the sequence completed");
        $fatal(1, "watchdog expired");
    end

endmodule
